sysref_capture_sequencer: RTL

- Gates one 128-bit RFDC ADC AXI4-Stream into a capture stream for exactly N beats, starting a programmable delay after a SYSREF rising edge.
- Gives deterministic, SYSREF-aligned snapshots across tiles for MTS checks.
- Sits between an RFDC mNN_axis output and a capture sink (FIFO/DMA), sequenced by PS-side control bits.
- The ADC side never stalls. Backpressure on the output is reported, not propagated.

---
 rtl/rfdc_cap_pkg.sv | 15 +
 rtl/sysref_edge_det.sv | 27 ++
 rtl/sysref_capture_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rfdc_cap_pkg.sv
// Shared types for the RFDC SYSREF-aligned capture path: sequencer state
// encoding and the default ADC beat width.
package rfdc_cap_pkg;

  localparam int ADC_BEAT_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    CAPTURE,
    DRAIN
  } cap_state_e;

endpackage

// File: rtl/sysref_edge_det.sv
// Registers a SYSREF already synchronised to clk and flags its rising edge in
// the cycle the new level first appears.
module sysref_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/sysref_capture_sequencer.sv
// Gates a never-stalling ADC AXI4-Stream into an N-beat capture that starts a
// programmable delay after a SYSREF rising edge; sink backpressure is only reported.
module sysref_capture_sequencer
  import rfdc_cap_pkg::*;
#(
  parameter int DATA_WIDTH  = ADC_BEAT_W,
  parameter int LEN_WIDTH   = 16,
  parameter int DELAY_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   clear,
  input  logic [LEN_WIDTH-1:0]   cfg_len,
  input  logic [DELAY_WIDTH-1:0] cfg_delay,
  input  logic                   sysref_in,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   cfg_err,
  output logic [LEN_WIDTH-1:0]   beat_count
);

  localparam logic [LEN_WIDTH-1:0]   LEN_ONE = 1;
  localparam logic [DELAY_WIDTH-1:0] DLY_ONE = 1;

  cap_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   beat_count_q, beat_count_d;
  logic [LEN_WIDTH-1:0]   beat_next;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d;
  logic [DELAY_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   sysref_rise;
  logic                   out_hs;
  logic                   out_stalled;

  sysref_edge_det u_sysref_edge (
    .clk    (aclk),
    .rst_n  (aresetn),
    .sig_in (sysref_in),
    .rise   (sysref_rise)
  );

  assign beat_next   = beat_count_q + LEN_ONE;
  assign out_hs      = tvalid_q & m_axis_tready;
  assign out_stalled = tvalid_q & ~m_axis_tready;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    delay_d      = delay_q;
    dcnt_d       = dcnt_q;
    beat_count_d = beat_count_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    done_d       = 1'b0;
    overflow_d   = overflow_q;
    cfg_err_d    = cfg_err_q;

    // Clear first so a same-cycle set below takes precedence.
    if (clear) begin
      overflow_d = 1'b0;
      cfg_err_d  = 1'b0;
    end

    if (abort) begin
      state_d  = IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      if (out_hs) begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (arm) begin
            if (cfg_len == '0) begin
              cfg_err_d = 1'b1;
            end else begin
              len_d        = cfg_len;
              delay_d      = cfg_delay;
              beat_count_d = '0;
              state_d      = ARMED;
            end
          end
        end
        ARMED: begin
          if (sysref_rise) begin
            if (delay_q == '0) begin
              state_d = CAPTURE;
            end else begin
              dcnt_d  = delay_q - DLY_ONE;
              state_d = DELAY;
            end
          end
        end
        DELAY: begin
          if (dcnt_q == '0) begin
            state_d = CAPTURE;
          end else begin
            dcnt_d = dcnt_q - DLY_ONE;
          end
        end
        CAPTURE: begin
          if (s_axis_tvalid) begin
            // A stalled beat is overwritten but still counted, keeping the window time-exact.
            tdata_d  = s_axis_tdata;
            tvalid_d = 1'b1;
            tlast_d  = (beat_next == len_q);
            if (out_stalled) begin
              overflow_d = 1'b1;
            end
            if (beat_count_q != len_q) begin
              beat_count_d = beat_next;
            end
            if (beat_next == len_q) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_hs) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      len_q        <= '0;
      delay_q      <= '0;
      dcnt_q       <= '0;
      beat_count_q <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      delay_q      <= delay_d;
      dcnt_q       <= dcnt_d;
      beat_count_q <= beat_count_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign cfg_err       = cfg_err_q;
  assign beat_count    = beat_count_q;

endmodule
